// File: rtl/uart_tx_buffer.sv
// Byte FIFO and transmit scheduler in front of a uart_basic transmitter.
// Define UART_TX_BUFFER_STATS_EN to add drop_count/sent_count outputs.
module uart_tx_buffer #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk_100M,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [DATA_WIDTH-1:0]    tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy
`ifdef UART_TX_BUFFER_STATS_EN
  ,
  output logic [15:0]              drop_count,
  output logic [15:0]              sent_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ?
                      $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;

  logic pop;
  logic push;
  logic drop;

  always_comb begin
    pop  = (state_q == S_IDLE) && !empty_q && !tx_busy;
    push = wr_en && (!full_q || pop);
    drop = wr_en && full_q && !pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    // a dropped write beats a same-cycle clear
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (clr_overflow)
      overflow_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          timer_d    = '0;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (tx_busy)
          state_d = S_WAIT_DONE;
        else if (timer_q == TW'(BUSY_TIMEOUT - 1))
          state_d = S_IDLE;
        else
          timer_d = timer_q + TW'(1);
      end
      S_WAIT_DONE: begin
        if (!tx_busy)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (push)
      mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      state_q    <= S_IDLE;
      timer_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

`ifdef UART_TX_BUFFER_STATS_EN
  logic [15:0] drop_count_q, drop_count_d;
  logic [15:0] sent_count_q, sent_count_d;

  always_comb begin
    drop_count_d = clr_overflow ? 16'h0 : drop_count_q;
    if (drop && drop_count_d != 16'hFFFF)
      drop_count_d = drop_count_d + 16'h1;
    sent_count_d = tx_start_d ? sent_count_q + 16'h1
                              : sent_count_q;
  end

  always_ff @(posedge clk_100M or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_q <= '0;
      sent_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign drop_count = drop_count_q;
  assign sent_count = sent_count_q;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomised bench for uart_tx_buffer with a queue-based reference model
// and a behavioural transmitter that holds tx_busy per frame.
module tb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int TMO   = 4;

  logic          clk_100M;
  logic          reset_n;
  logic [DW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [4:0]    count;
  logic          overflow;
  logic          clr_overflow;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy;
`ifdef UART_TX_BUFFER_STATS_EN
  logic [15:0]   drop_count;
  logic [15:0]   sent_count;
`endif

  uart_tx_buffer #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk_100M    (clk_100M),
    .reset_n     (reset_n),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy)
`ifdef UART_TX_BUFFER_STATS_EN
    ,
    .drop_count  (drop_count),
    .sent_count  (sent_count)
`endif
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // transmitter model: 0 = frames of flen cycles, 1 = busy held, 2 = never busy
  int busy_mode = 0;
  int flen      = 10;
  int left      = 0;

  initial tx_busy = 1'b0;
  always @(posedge clk_100M) begin
    #2;
    case (busy_mode)
      1: tx_busy = 1'b1;
      2: tx_busy = 1'b0;
      default: begin
        if (tx_start && left == 0) left = flen;
        if (left > 0) begin
          tx_busy = 1'b1;
          left--;
        end else begin
          tx_busy = 1'b0;
        end
      end
    endcase
  end

  // reference model and monitor
  logic [DW-1:0] q[$];
  logic [DW-1:0] out_log[$];
  int            starts[$];
  int            cyc     = 0;
  int            sent_n  = 0;
  logic          ovf_m   = 1'b0;
  logic          prev_st = 1'b0;
  logic [15:0]   drop_m  = '0;
  logic [15:0]   sent_m  = '0;

  always @(posedge clk_100M) begin
    logic          busy_s, wr_s, clr_s, drop;
    logic [DW-1:0] d_s, exp_b;
    busy_s = tx_busy;
    wr_s   = wr_en;
    d_s    = wr_data;
    clr_s  = clr_overflow;
    #1;
    cyc++;
    if (!reset_n) begin
      q.delete();
      ovf_m   = 1'b0;
      prev_st = 1'b0;
      drop_m  = '0;
      sent_m  = '0;
    end else begin
      drop = 1'b0;
      if (tx_start) begin
        chk("start_busy", {31'd0, busy_s}, 0);
        chk("start_width", {31'd0, prev_st}, 0);
        chk("pop_nonempty", {31'd0, q.size() != 0}, 1);
        if (q.size() != 0) begin
          exp_b = q.pop_front();
          chk("tx_data", {24'd0, tx_data}, {24'd0, exp_b});
        end
        out_log.push_back(tx_data);
        starts.push_back(cyc);
        sent_n++;
        sent_m++;
      end
      if (wr_s) begin
        if (q.size() < DEPTH) q.push_back(d_s);
        else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (clr_s) ovf_m = 1'b0;
      if (clr_s) drop_m = drop ? 16'd1 : 16'd0;
      else if (drop && drop_m != 16'hFFFF) drop_m++;
      chk("count", {27'd0, count}, q.size());
      chk("full", {31'd0, full}, {31'd0, q.size() == DEPTH});
      chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
      chk("overflow", {31'd0, overflow}, {31'd0, ovf_m});
`ifdef UART_TX_BUFFER_STATS_EN
      chk("drop_count", {16'd0, drop_count}, {16'd0, drop_m});
      chk("sent_count", {16'd0, sent_count}, {16'd0, sent_m});
`endif
      prev_st = tx_start;
    end
  end

  int peak = 0;

  task automatic wait_sent(input int target, input int budget);
    int k = 0;
    while (sent_n < target && k < budget) begin
      @(negedge clk_100M);
      k++;
      if (int'(count) > peak) peak = int'(count);
    end
    if (sent_n < target) chk("wait_timeout", sent_n, target);
  endtask

  task automatic settle(input int budget);
    int k = 0;
    while ((q.size() != 0 || tx_busy) && k < budget) begin
      @(negedge clk_100M);
      k++;
    end
    if (q.size() != 0 || tx_busy) chk("settle_timeout", q.size(), 0);
    repeat (3) @(negedge clk_100M);
  endtask

  task automatic put(input logic [DW-1:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk_100M);
    wr_en   = 1'b0;
  endtask

  initial begin
    int            base;
    logic [DW-1:0] exp_l[$];
    reset_n      = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk_100M);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_count", {27'd0, count}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_txdata", {24'd0, tx_data}, 0);
    chk("rst_start", {31'd0, tx_start}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_100M);

    // single byte latency
    wr_en   = 1'b1;
    wr_data = 8'h41;
    @(negedge clk_100M);
    wr_en = 1'b0;
    chk("lat_n1", {31'd0, tx_start}, 0);
    @(negedge clk_100M);
    chk("lat_n2", {31'd0, tx_start}, 1);
    chk("lat_data", {24'd0, tx_data}, 32'h41);
    settle(200);
    chk("single_cnt", {27'd0, count}, 0);
    chk("single_empty", {31'd0, empty}, 1);

    // burst of 5 behind a slow transmitter
    flen = 100;
    base = sent_n;
    peak = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      @(negedge clk_100M);
      if (int'(count) > peak) peak = int'(count);
    end
    wr_en = 1'b0;
    wait_sent(base + 5, 1000);
    chk("burst_peak", {31'd0, peak >= 4 && peak <= 5}, 1);
    for (int i = 0; i < 5; i++)
      chk("burst_order", {24'd0, out_log[base + i]}, 32'h10 + i);
    settle(300);

    // overflow with transmitter held busy
    busy_mode = 1;
    repeat (2) @(negedge clk_100M);
    base = sent_n;
    for (int i = 0; i < 17; i++) put(8'(8'h60 + i));
    chk("ovf_count", {27'd0, count}, 16);
    chk("ovf_full", {31'd0, full}, 1);
    chk("ovf_flag", {31'd0, overflow}, 1);
    clr_overflow = 1'b1;
    @(negedge clk_100M);
    clr_overflow = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 0);

    // write into a full FIFO on the same cycle as a pop
    flen      = 5;
    busy_mode = 0;
    @(negedge clk_100M);
    put(8'h80);
    chk("cw_start", {31'd0, tx_start}, 1);
    chk("cw_count", {27'd0, count}, 16);
    chk("cw_full", {31'd0, full}, 1);
    chk("cw_ovf", {31'd0, overflow}, 0);
    wait_sent(base + 17, 2000);
    for (int i = 0; i < 16; i++)
      chk("ovf_order", {24'd0, out_log[base + i]}, 32'h60 + i);
    chk("cw_order", {24'd0, out_log[base + 16]}, 32'h80);
    settle(200);

    // wrap-around: 40 bytes through the 16-deep buffer
    flen = 3;
    base = sent_n;
    exp_l.delete();
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] b;
      int k = 0;
      while (q.size() >= DEPTH && k < 500) begin
        @(negedge clk_100M);
        k++;
      end
      b = 8'($urandom);
      exp_l.push_back(b);
      put(b);
    end
    wait_sent(base + 40, 3000);
    for (int i = 0; i < 40; i++)
      chk("wrap_order", {24'd0, out_log[base + i]},
          {24'd0, exp_l[i]});
    settle(200);

    // transmitter that never raises busy
    busy_mode = 2;
    base = sent_n;
    put(8'hA1);
    put(8'hA2);
    wait_sent(base + 2, 100);
    chk("tmo_gap", starts[base + 1] - starts[base], TMO + 1);
    chk("tmo_b0", {24'd0, out_log[base]}, 32'hA1);
    chk("tmo_b1", {24'd0, out_log[base + 1]}, 32'hA2);
    repeat (10) @(negedge clk_100M);

    // reset while waiting for the frame to finish
    busy_mode = 0;
    flen      = 60;
    base      = sent_n;
    put(8'hC1);
    put(8'hC2);
    put(8'hC3);
    wait_sent(base + 1, 100);
    repeat (10) @(negedge clk_100M);
    reset_n = 1'b0;
    #1;
    chk("mr_start", {31'd0, tx_start}, 0);
    chk("mr_txdata", {24'd0, tx_data}, 0);
    chk("mr_count", {27'd0, count}, 0);
    chk("mr_empty", {31'd0, empty}, 1);
    chk("mr_full", {31'd0, full}, 0);
    chk("mr_ovf", {31'd0, overflow}, 0);
    repeat (3) @(negedge clk_100M);
    reset_n = 1'b1;
    base = sent_n;
    repeat (120) @(negedge clk_100M);
    chk("mr_nostart", sent_n - base, 0);

`ifdef UART_TX_BUFFER_STATS_EN
    busy_mode = 1;
    repeat (2) @(negedge clk_100M);
    for (int i = 0; i < 19; i++) put(8'(i));
    chk("st_drops", {16'd0, drop_count}, 3);
    clr_overflow = 1'b1;
    @(negedge clk_100M);
    clr_overflow = 1'b0;
    chk("st_drop_clr", {16'd0, drop_count}, 0);
    busy_mode = 0;
    flen      = 3;
    for (int i = 0; i < 4; i++) put(8'(8'h50 + i));
    wait_sent(sent_n + 20 - int'(sent_count), 2000);
    chk("st_sent", {16'd0, sent_count}, 20);
    settle(200);
`endif

    // randomised traffic
    busy_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) flen = int'($urandom_range(2, 25));
      wr_en        = ($urandom % 3) == 0;
      wr_data      = 8'($urandom);
      clr_overflow = ($urandom % 50) == 0;
      @(negedge clk_100M);
    end
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
    settle(2000);
    chk("rand_drained", {27'd0, count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
